serial_sort_arith: RTL and testbench

//  Collects a frame of NUM signed samples serially and sorts them in place with a

---
 rtl/serial_sort_arith_if.sv | 25 ++
 rtl/serial_sort_arith.sv | 137 +++++++++++++
 tb/tb_serial_sort_arith.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_sort_arith_if.sv
// Sample-in / result-out bundle for serial_sort_arith.
// The front-end drives the master side; the sorter implements the slave side.
interface serial_sort_arith_if #(
    parameter int DATA_W = 4,
    parameter int NUM    = 4
);
    localparam int RES_W = DATA_W + $clog2(NUM) + 1;

    logic                     in_valid;
    logic signed [DATA_W-1:0] in_number;
    logic [2:0]               mode;
    logic                     busy;
    logic                     out_valid;
    logic signed [RES_W-1:0]  out_result;

    modport master (
        output in_valid, in_number, mode,
        input  busy, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_number, mode,
        output busy, out_valid, out_result
    );
endinterface

// File: rtl/serial_sort_arith.sv
// Serial frame collector with an odd-even transposition sorter (one pass per cycle)
// followed by a mode-selected reduction that is emitted as a one-cycle result strobe.
module serial_sort_arith #(
    parameter int DATA_W = 4,
    parameter int NUM    = 4
) (
    input logic          clk,
    input logic          rst_n,
    serial_sort_arith_if.slave bus
);
    localparam int RES_W = DATA_W + $clog2(NUM) + 1;
    localparam int IDX_W = $clog2(NUM);
    localparam int MED   = (NUM - 1) / 2;

    typedef enum logic [2:0] {IDLE, LOAD, SORT, CALC, OUT} state_t;

    state_t                   state;
    logic [IDX_W-1:0]         cnt;
    logic [IDX_W-1:0]         pass;
    logic [2:0]               mode_r;
    logic signed [DATA_W-1:0] samp     [NUM];
    logic signed [DATA_W-1:0] samp_nxt [NUM];
    logic signed [RES_W-1:0]  sum_all;
    logic [RES_W-1:0]         neg_cnt;
    logic signed [RES_W-1:0]  calc_res;
    logic signed [RES_W-1:0]  res_r;
    logic                     busy_r;
    logic                     ov_r;

    function automatic logic signed [RES_W-1:0] sext(input logic signed [DATA_W-1:0] x);
        return RES_W'(x);
    endfunction

    // Even passes pair (0,1),(2,3)..; odd passes (1,2),(3,4)..; pairs never overlap.
    always_comb begin
        samp_nxt = samp;
        for (int i = 0; i < NUM - 1; i++) begin
            if (((i % 2) == 1) == pass[0] && samp[i] > samp[i+1]) begin
                samp_nxt[i]   = samp[i+1];
                samp_nxt[i+1] = samp[i];
            end
        end
    end

    always_comb begin
        sum_all = '0;
        neg_cnt = '0;
        for (int i = 0; i < NUM; i++) begin
            sum_all = sum_all + sext(samp[i]);
            neg_cnt = neg_cnt + RES_W'(samp[i][DATA_W-1]);
        end
    end

    always_comb begin
        calc_res = '0;
        case (mode_r)
            3'd0:    calc_res = sext(samp[0]) + sext(samp[1]);
            3'd1:    calc_res = sext(samp[1]) - sext(samp[0]);
            3'd2:    calc_res = sext(samp[NUM-1]) - sext(samp[NUM-2]);
            3'd3:    calc_res = sext(samp[0]) + sext(samp[NUM-1]);
            3'd4:    calc_res = sum_all;
            3'd5:    calc_res = sext(samp[MED]);
            3'd6:    calc_res = sext(samp[NUM-1]) - sext(samp[0]);
            3'd7:    calc_res = signed'(neg_cnt);
            default: calc_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            pass   <= '0;
            mode_r <= '0;
            busy_r <= 1'b0;
            ov_r   <= 1'b0;
            res_r  <= '0;
            for (int i = 0; i < NUM; i++) samp[i] <= '0;
        end else begin
            // Result register is only non-zero during the single OUT cycle.
            ov_r  <= 1'b0;
            res_r <= '0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        samp[0] <= bus.in_number;
                        mode_r  <= bus.mode;
                        cnt     <= IDX_W'(1);
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        samp[cnt] <= bus.in_number;
                        if (cnt == IDX_W'(NUM - 1)) begin
                            pass   <= '0;
                            busy_r <= 1'b1;
                            state  <= SORT;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                SORT: begin
                    samp <= samp_nxt;
                    if (pass == IDX_W'(NUM - 1)) state <= CALC;
                    else                         pass  <= pass + 1'b1;
                end
                CALC: begin
                    res_r  <= calc_res;
                    ov_r   <= 1'b1;
                    busy_r <= 1'b0;
                    cnt    <= '0;
                    state  <= OUT;
                end
                OUT: begin
                    if (bus.in_valid) begin
                        samp[0] <= bus.in_number;
                        mode_r  <= bus.mode;
                        cnt     <= IDX_W'(1);
                        state   <= LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.out_valid  = ov_r;
    assign bus.out_result = res_r;
endmodule

// File: tb/tb_serial_sort_arith.sv
// Bench for serial_sort_arith: directed frames plus random frames on two configurations,
// checked against a sort-then-reduce reference model.
module tb_serial_sort_arith;
    localparam int A_W = 4;
    localparam int A_N = 4;
    localparam int B_W = 6;
    localparam int B_N = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_sort_arith_if #(.DATA_W(A_W), .NUM(A_N)) ifa ();
    serial_sort_arith_if #(.DATA_W(B_W), .NUM(B_N)) ifb ();

    serial_sort_arith #(.DATA_W(A_W), .NUM(A_N)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    serial_sort_arith #(.DATA_W(B_W), .NUM(B_N)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: plain sort of the frame, then the reduction applied to the sorted list.
    function automatic int model(input int s_in[$], input int m);
        int s[$];
        int n, t, r;
        s = s_in;
        n = s.size();
        for (int i = 1; i < n; i++)
            for (int j = i; j > 0 && s[j-1] > s[j]; j--) begin
                t = s[j]; s[j] = s[j-1]; s[j-1] = t;
            end
        r = 0;
        case (m)
            0: r = s[0] + s[1];
            1: r = s[1] - s[0];
            2: r = s[n-1] - s[n-2];
            3: r = s[0] + s[n-1];
            4: foreach (s[i]) r += s[i];
            5: r = s[(n-1)/2];
            6: r = s[n-1] - s[0];
            default: foreach (s[i]) if (s[i] < 0) r++;
        endcase
        return r;
    endfunction

    function automatic int rnd_sample(input int w);
        int v;
        v = int'($urandom_range(0, (1 << w) - 1));
        return (v >= (1 << (w - 1))) ? v - (1 << w) : v;
    endfunction

    function automatic int get_ov(input int sel);
        return (sel == 0) ? int'(ifa.out_valid) : int'(ifb.out_valid);
    endfunction
    function automatic int get_busy(input int sel);
        return (sel == 0) ? int'(ifa.busy) : int'(ifb.busy);
    endfunction
    function automatic int get_res(input int sel);
        return (sel == 0) ? int'(ifa.out_result) : int'(ifb.out_result);
    endfunction

    task automatic drive(input int sel, input int v, input int num, input int m);
        if (sel == 0) begin
            ifa.in_valid = v[0]; ifa.in_number = A_W'(num); ifa.mode = 3'(m);
        end else begin
            ifb.in_valid = v[0]; ifb.in_number = B_W'(num); ifb.mode = 3'(m);
        end
    endtask

    // Entered at a falling edge; returns at the falling edge after the last capture edge.
    task automatic send(input int sel, input int q[$], input int m, input int n_send);
        for (int i = 0; i < n_send; i++) begin
            drive(sel, 1, q[i], m);
            @(negedge clk);
        end
        drive(sel, 0, 0, 0);
    endtask

    // Returns at the falling edge inside the OUT cycle (or after the budget expires).
    task automatic wait_result(input int sel, input int exp, input string tag,
                               input int nn, input int pulse);
        int  k;
        bit  found, busy_ok, zero_ok;
        k = 1; found = 0; busy_ok = 1; zero_ok = 1;
        while (k <= 40) begin
            if (get_ov(sel) == 1) begin
                found = 1;
                break;
            end
            if (get_busy(sel) != int'(k <= nn + 1)) busy_ok = 0;
            if (get_res(sel) != 0) zero_ok = 0;
            if (pulse != 0 && k == 2) drive(sel, 1, rnd_sample(sel == 0 ? A_W : B_W), 7);
            if (pulse != 0 && k == 3) drive(sel, 0, 0, 0);
            @(negedge clk);
            k++;
        end
        check({tag, "_seen"}, int'(found), 1);
        if (found) begin
            check({tag, "_latency"}, k - 1, nn + 1);
            check({tag, "_result"}, get_res(sel), exp);
            check({tag, "_busy_out"}, get_busy(sel), 0);
        end
        check({tag, "_busy_window"}, int'(busy_ok), 1);
        check({tag, "_zero_offstrobe"}, int'(zero_ok), 1);
    endtask

    task automatic frame(input int sel, input int q[$], input int m, input int exp,
                         input string tag, input int pulse);
        int nn;
        nn = q.size();
        send(sel, q, m, nn);
        wait_result(sel, exp, tag, nn, pulse);
        @(negedge clk);
        check({tag, "_post_valid"}, get_ov(sel), 0);
        check({tag, "_post_result"}, get_res(sel), 0);
    endtask

    task automatic watch_quiet(input int sel, input int n, input string tag);
        bit ok;
        ok = 1;
        repeat (n) begin
            if (get_ov(sel) != 0) ok = 0;
            @(negedge clk);
        end
        check(tag, int'(ok), 1);
    endtask

    initial begin
        int q[$];
        int m, nn;
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("rst_a_valid", get_ov(0), 0);
        check("rst_a_busy", get_busy(0), 0);
        check("rst_a_result", get_res(0), 0);
        check("rst_b_valid", get_ov(1), 0);
        rst_n = 1'b1;
        @(negedge clk);

        frame(0, '{3, -2, 7, 0}, 0, -2, "m0", 0);
        frame(0, '{3, -2, 7, 0}, 1, 2, "m1", 0);
        frame(0, '{3, -2, 7, 0}, 2, 4, "m2", 0);
        frame(0, '{3, -2, 7, 0}, 3, 5, "m3", 0);
        frame(0, '{3, -2, 7, 0}, 5, 0, "m5", 0);
        frame(0, '{3, -2, 7, 0}, 6, 9, "m6", 0);
        frame(0, '{3, -2, 7, 0}, 7, 1, "m7", 0);
        frame(0, '{-8, -8, -8, -8}, 4, -32, "sum_min", 0);
        frame(0, '{7, 7, 7, 7}, 4, 28, "sum_max", 0);
        frame(0, '{-8, 7, 0, 0}, 6, 15, "range_full", 0);

        send(0, '{5, 6, 0, 0}, 4, 2);
        watch_quiet(0, 10, "abort_quiet");
        frame(0, '{1, 2, 3, 4}, 3, 5, "after_abort", 0);

        frame(0, '{3, -2, 7, 0}, 6, 9, "pulse_sort", 1);

        send(0, '{1, -5, 2, 2}, 4, 4);
        wait_result(0, 0, "b2b_first", 4, 0);
        frame(0, '{-1, -2, -3, -4}, 7, 4, "b2b_second", 0);

        send(0, '{5, 1, 2, 3}, 4, 4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", get_ov(0), 0);
        check("midrst_busy", get_busy(0), 0);
        check("midrst_result", get_res(0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_quiet(0, 10, "midrst_quiet");

        frame(1, '{5, -1, 3, -20, 9}, 5, 3, "b_median", 0);
        frame(1, '{5, -1, 3, -20, 9}, 4, -4, "b_sum", 0);

        for (int f = 0; f < 30; f++) begin
            q = {};
            for (int i = 0; i < A_N; i++) q.push_back(rnd_sample(A_W));
            m = int'($urandom_range(0, 7));
            frame(0, q, m, model(q, m), "rnd_a", int'($urandom_range(0, 1)));
        end
        for (int f = 0; f < 15; f++) begin
            q = {};
            for (int i = 0; i < B_N; i++) q.push_back(rnd_sample(B_W));
            m = int'($urandom_range(0, 7));
            nn = int'($urandom_range(0, 2));
            repeat (nn) @(negedge clk);
            frame(1, q, m, model(q, m), "rnd_b", int'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
